// File: rtl/mux_canal_reg.sv
// mux_canal_reg -- N-channel, W-bit registered multiplexer with a one-entry
// output register, a stored select register and an optional round-robin scan.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   mode       0 = fixed select (cur_sel), 1 = round-robin scan
//   sel_in     new select / pointer value
//   sel_load   load sel_in into the select register at the next edge
//   in_data    N packed channels, channel i at bits [i*W +: W]
//   in_valid   per-channel data valid
//   in_ready   per-channel accept, at most one bit set
//   out_data   registered output data
//   out_valid  output register holds data
//   out_ready  consumer accepts out_data
//   cur_sel    select register (fixed mode) / last-granted pointer (RR mode)
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high. A producer holds valid/data until it sees ready;
// ready never waits on valid in fixed mode. The output slot may drain and
// refill on the same edge, so sustained throughput is one word per cycle.

module mux_canal_reg #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_load,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] cur_sel
);

    logic             space;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic [W-1:0]     grant_data;
    logic             transfer;

    // Output slot is free when empty or being drained this cycle.
    assign space = !out_valid || out_ready;

    // Grant selection. In RR mode the search starts one past the stored
    // pointer (taken modulo N, so out-of-range pointers still work) and ends
    // back at the pointer itself.
    always_comb begin
        int start;
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        start       = int'(cur_sel) % N;
        cand        = 0;
        if (!mode) begin
            if (int'(cur_sel) < N) begin
                grant_found = 1'b1;
                grant_idx   = cur_sel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = (start + k) % N;
                for (int j = 0; j < N; j++) begin
                    if (!grant_found && j == cand && in_valid[j]) begin
                        grant_found = 1'b1;
                        grant_idx   = SEL_W'(j);
                    end
                end
            end
        end
    end

    // Route the granted channel's valid and data; only indices < N exist.
    always_comb begin
        grant_valid = 1'b0;
        grant_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant_idx) == i) begin
                grant_valid = in_valid[i];
                grant_data  = in_data[i*W +: W];
            end
        end
    end

    // in_ready is held low during reset so nothing appears accepted.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && grant_found && space && (int'(grant_idx) == i);
        end
    end

    assign transfer = rst_n && grant_found && space && grant_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cur_sel   <= '0;
        end else begin
            if (transfer) begin
                out_data  <= grant_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // An explicit load beats the round-robin pointer advance.
            if (sel_load) begin
                cur_sel <= sel_in;
            end else if (mode && transfer) begin
                cur_sel <= grant_idx;
            end
        end
    end

endmodule
